// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// one bit per clock under a start/busy/done handshake.

module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_sum, fa_cout;

  serial_adder_fa u_fa (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    s_d      = s_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        // Subtraction is a + ~b + 1, so the inverted operand and forced carry are loaded here.
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = sub ? ~b : b;
          carry_d  = sub ? 1'b1 : ci;
          sum_sh_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d  = fa_cout;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this edge.
          s_d     = sum_sh_d;
          co_d    = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      s_q      <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      s_q      <= s_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell plus a carry flip-flop. It processes one bit per clock, LSB first, under a start/busy/done handshake. It generalises the combinational one-bit full adder to WIDTH-bit operands, adds a subtract mode and signed-overflow detection, and trades latency for area. It sits beside the full adder in the lab datapath as the area-minimal arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the unit is idle or in its done cycle.
- sub  in  1  0 = a+b+ci; 1 = a-b (ci ignored); latched with start.
- a  in  WIDTH  operand A; latched on the accepted start edge.
- b  in  WIDTH  operand B; latched on the accepted start edge.
- ci  in  1  carry-in for add mode; latched with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when s/co/ovf become valid.
- s  out  WIDTH  result; held until the next result is loaded.
- co  out  1  carry out of the MSB; in subtract mode 1 = no borrow.
- ovf  out  1  two's-complement overflow (carry into MSB xor carry out of MSB).

## Operation
- States: IDLE, RUN, DONE.
- Reset (synchronous, dominant over everything):
  - state = IDLE; bit counter = 0; carry flip-flop = 0.
  - s = 0, co = 0, ovf = 0, busy = 0, done = 0.
- IDLE: on a start=1 edge, take all of the following on that edge, then go to RUN:
  - load a_sh = a and b_sh = sub ? ~b : b;
  - carry = sub ? 1 : ci;
  - counter = 0, busy = 1.
- RUN, on every edge:
  - sum_bit = a_sh[0] ^ b_sh[0] ^ carry;
  - carry = majority(a_sh[0], b_sh[0], carry);
  - shift sum_bit into the MSB of the internal sum shifter, with the shifter moving right;
  - shift a_sh and b_sh right by one;
  - counter = counter + 1.
  - When counter = WIDTH-1, record the carry-in of this bit (the MSB) for overflow.
- On the edge that processes bit WIDTH-1, all in the same edge:
  - s = completed sum shifter;
  - co = final carry;
  - ovf = MSB carry-in xor final carry;
  - busy = 0, done = 1, state = DONE.
- DONE lasts exactly one cycle:
  - done = 1 and results are valid.
  - On the next edge, start=1 starts a new operation exactly as from IDLE (back-to-back); otherwise go to IDLE.
  - done clears on that edge in either case.
- start while in RUN is ignored. a, b, sub and ci may change freely after the accepting edge.
- s, co and ovf change only on the done edge or on reset. Intermediate shifter contents never appear on s.
- Counter is wide enough to hold WIDTH-1 and never wraps past it.

## Timing
- Accepting start edge = edge 0. Bits are processed on edges 1..WIDTH. done rises at edge WIDTH and falls at edge WIDTH+1.
- Latency from start to done = WIDTH cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- busy is high from edge 0 to edge WIDTH, so it is low in the done cycle.
- busy and done are never high together.
- Reset asserted mid-RUN aborts the operation:
  - no done pulse is produced;
  - s, co and ovf return to 0 on that edge;
  - a start on the first edge after reset deasserts is accepted.
- Simultaneous reset and start: reset wins and start is dropped.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, sub=0, ci=0 -> done exactly 8 edges after start; s=0x8D, co=0, ovf=1.
- a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, ovf=0. Then a=0x00, b=0x00, ci=1 -> s=0x01, co=0, ovf=0.
- sub=1: a=0x10, b=0x20 -> s=0xF0, co=0, ovf=0. Then a=0x80, b=0x01 -> s=0x7F, co=1, ovf=1.
- Hold start=1 continuously with a new operand every cycle:
  - a result is produced every 9 cycles;
  - start pulses during RUN are ignored and operands from a non-accepting edge never affect the result;
  - busy and done are never high together.
- Assert reset at edge 4 of an operation:
  - no done pulse; s=0, co=0, busy=0 after that edge;
  - a fresh start of 0x01+0x02 gives s=0x03.
- Exhaustive sweep, WIDTH=4: all a, b, ci and sub combinations are compared against a reference model (sum mod 16, carry out, overflow). This generalises the 3-bit counter sweep used for the one-bit full adder.
